// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
//   Round-robin arbiter that lets one of N_REQ pixel producers own the VGA
//   adapter write port for a burst. In-range beats from the owner are
//   forwarded one cycle later as a plot pulse; out-of-range beats are dropped
//   and counted. A burst is capped at MAX_BURST accepted beats.
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   req                per-requester bus request
//   req_valid/last     per-requester beat valid / last beat of burst
//   req_x/req_y        packed 8-bit coordinates, requester i in [8i+7:8i]
//   req_colour         packed 3-bit colours, requester i in [3i+2:3i]
//   gnt                one-hot grant (all zero in IDLE)
//   x, y, colour, plot registered pixel write to the VGA adapter
//   owner              current or most recent grantee (round-robin pointer)
//   busy               high while a burst is in progress
//   drop_count         saturating count of clipped pixels
module pixel_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 32,
  parameter int X_LIMIT   = 160,
  parameter int Y_LIMIT   = 120
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [8*N_REQ-1:0]       req_x,
  input  logic [8*N_REQ-1:0]       req_y,
  input  logic [3*N_REQ-1:0]       req_colour,
  output logic [N_REQ-1:0]         gnt,
  output logic [7:0]               x,
  output logic [7:0]               y,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [7:0]               drop_count
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
  } pix_t;

  state_t                         state;
  logic [CW-1:0]                  beat_cnt;
  logic [N_REQ-1:0][7:0]          lane_x;
  logic [N_REQ-1:0][7:0]          lane_y;
  logic [N_REQ-1:0][2:0]          lane_c;
  pix_t                           pix;
  logic                           accept;
  logic                           in_range;
  logic                           last_cap;
  logic [OW-1:0]                  rr_sel;
  logic [OW-1:0]                  rr_idx;
  logic                           rr_found;

  assign lane_x = req_x;
  assign lane_y = req_y;
  assign lane_c = req_colour;

  // Only the owner's lane matters; everyone else is ignored during a burst.
  assign pix      = '{x: lane_x[owner], y: lane_y[owner], colour: lane_c[owner]};
  assign accept   = (state == BURST) && req_valid[owner] && gnt[owner];
  assign in_range = (int'(pix.x) < X_LIMIT) && (int'(pix.y) < Y_LIMIT);
  // This accepted beat is the last one the burst is allowed.
  assign last_cap = (beat_cnt == CW'(MAX_BURST - 1));

  // Round-robin scan starting one past the previous owner, so the most
  // recent grantee has the lowest priority next time.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = owner;
    rr_idx   = owner;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = OW'((int'(owner) + k) % N_REQ);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      gnt        <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      owner      <= OW'(N_REQ - 1);
      busy       <= 1'b0;
      drop_count <= '0;
      beat_cnt   <= '0;
    end else begin
      // Pixel port defaults to quiet; only an accepted in-range beat writes.
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            owner    <= rr_sel;
            gnt      <= N_REQ'(1) << rr_sel;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (in_range) begin
              plot   <= 1'b1;
              x      <= pix.x;
              y      <= pix.y;
              colour <= pix.colour;
            end else if (drop_count != 8'hFF) begin
              drop_count <= drop_count + 8'd1;
            end
            // req[owner] is irrelevant once a beat is accepted: the last flag
            // or the burst cap decides whether the burst ends.
            if (req_last[owner] || last_cap) begin
              gnt   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (!req[owner]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
